// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// A byte moves on every rising edge where byte_valid and byte_ready are both 1.
// The producer keeps byte_data stable while byte_valid is high and no transfer has occurred.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] wr_addr0;
    logic [31:0] wr_din0;
    logic        we0;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, wr_addr0, wr_din0, we0
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, wr_addr0, wr_din0, we0
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive imem word addresses, holding the core until done.
module imem_loader #(
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.master     bus,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum,
    output logic [ADDR_W:0]   words_loaded,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic start_acc, len_bad, accept, word_full, last_word, timed_out;

    assign start_acc = start && (state_q != S_LOAD);
    assign len_bad   = (len == '0) || (len > (ADDR_W+1)'(DEPTH));
    assign accept    = bus.byte_valid && ready_q;
    assign word_full = accept && (byte_idx_q == 2'd3);
    assign last_word = word_full && ((words_q + (ADDR_W+1)'(1)) == len_q);
    // Timeout fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timed_out = (state_q == S_LOAD) && !accept &&
                       ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (last_word)      state_d = S_DONE;
                else if (timed_out) state_d = S_ERR;
            end
            default: begin
                if (start_acc) state_d = len_bad ? S_ERR : S_LOAD;
            end
        endcase
    end

    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        words_d    = words_q;
        to_cnt_d   = to_cnt_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        hold_d     = hold_q;
        err_d      = err_q;
        ready_d    = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD);
        if (start_acc) begin
            byte_idx_d = '0;
            word_idx_d = '0;
            words_d    = '0;
            to_cnt_d   = '0;
            sum_d      = '0;
            len_d      = len;
            hold_d     = 1'b1;
            err_d      = len_bad;
        end else if (state_q == S_LOAD) begin
            if (accept) begin
                sum_d      = sum_q + bus.byte_data;
                to_cnt_d   = '0;
                byte_idx_d = byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: asm_d[7:0]   = bus.byte_data;
                    2'd1: asm_d[15:8]  = bus.byte_data;
                    2'd2: asm_d[23:16] = bus.byte_data;
                    default: begin
                        we_d       = 1'b1;
                        din_d      = {bus.byte_data, asm_q};
                        addr_d     = 32'(word_idx_q);
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        words_d    = words_q + (ADDR_W+1)'(1);
                    end
                endcase
                if (last_word) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (timed_out) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
            word_idx_q <= '0;
            len_q      <= '0;
            words_q    <= '0;
            to_cnt_q   <= '0;
            sum_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            words_q    <= words_d;
            to_cnt_q   <= to_cnt_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            ready_q    <= ready_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.wr_addr0   = addr_q;
    assign bus.wr_din0    = din_q;
    assign bus.we0        = we_q;
    assign core_hold      = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign checksum       = sum_q;
    assign words_loaded   = words_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a per-cycle behavioural model of the loader is checked
// against every output, and directed phases pin the model with literal write lists.
module tb_imem_loader;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       core_hold, busy, done, err;
    logic [7:0] checksum;
    logic [7:0] words_loaded;
    logic [1:0] state_dbg;

    imem_loader_if bus();

    imem_loader #(.DEPTH(128), .ADDR_W(7), .TIMEOUT_CYCLES(TIMEOUT), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bus(bus),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err),
        .checksum(checksum), .words_loaded(words_loaded), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] wlog[$];
    logic [7:0]  tx_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // behavioural model: loading flag, partial word as a byte queue, plain sums
    bit          m_load = 1'b0;
    int          m_len = 0, m_idle = 0, m_sum = 0;
    logic [7:0]  m_part[$];
    logic        e_ready = 0, e_we = 0, e_hold = 1, e_busy = 0, e_done = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_din = 0;
    logic [7:0]  e_words = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_load = 0; m_idle = 0; m_sum = 0; m_part.delete();
                e_we = 0; e_addr = 0; e_din = 0; e_hold = 1; e_done = 0; e_err = 0; e_words = 0;
            end else begin
                e_we = 0;
                e_done = 0;
                if (start && !m_load) begin
                    m_sum = 0; m_idle = 0; m_part.delete(); e_words = 0; e_hold = 1;
                    if (len == 0 || len > 128) begin
                        e_err = 1; m_load = 0;
                    end else begin
                        e_err = 0; m_load = 1; m_len = int'(len);
                    end
                end else if (m_load) begin
                    if (bus.byte_valid) begin
                        m_part.push_back(bus.byte_data);
                        m_sum = (m_sum + int'(bus.byte_data)) % 256;
                        m_idle = 0;
                        if (m_part.size() == 4) begin
                            e_we = 1;
                            e_din = 32'(m_part[0]) | (32'(m_part[1]) << 8) |
                                    (32'(m_part[2]) << 16) | (32'(m_part[3]) << 24);
                            e_addr = 32'(e_words);
                            e_words = e_words + 8'd1;
                            m_part.delete();
                            if (int'(e_words) == m_len) begin
                                m_load = 0; e_done = 1; e_hold = 0;
                            end
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            m_load = 0; e_err = 1;
                        end
                    end
                end
            end
            e_ready = m_load;
            e_busy  = m_load;
            @(negedge clk);
            chk("byte_ready", 64'(bus.byte_ready), 64'(e_ready));
            chk("we0", 64'(bus.we0), 64'(e_we));
            chk("wr_addr0", 64'(bus.wr_addr0), 64'(e_addr));
            chk("wr_din0", 64'(bus.wr_din0), 64'(e_din));
            chk("core_hold", 64'(core_hold), 64'(e_hold));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(e_err));
            chk("checksum", 64'(checksum), 64'(m_sum));
            chk("words_loaded", 64'(words_loaded), 64'(e_words));
            if (bus.we0 === 1'b1) wlog.push_back({bus.wr_addr0, bus.wr_din0});
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bytes(input int gap_max, input int start_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            int g;
            int n;
            bit acc;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            bus.byte_valid = 1'b0;
            repeat (g) tick();
            if (i == start_at) begin
                start = 1'b1; len = 8'd5;
                tick();
                start = 1'b0;
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = tx_q[i];
            n = 0;
            acc = 1'b0;
            while (!acc && n < 40) begin
                acc = bus.byte_ready;
                tick();
                n++;
            end
            chk("byte_accepted", 64'(acc), 64'd1);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk({tag, "_write"}, wlog[i], exp_q[i]);
        wlog.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_core_hold", 64'(core_hold), 64'd1);
        chk("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
        chk("rst_we0", 64'(bus.we0), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // nominal load
        wlog.delete();
        tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q = '{{32'd0, 32'h0000_0013}, {32'd1, 32'h0010_0093}};
        do_start(8'd2);
        send_bytes(0, -1);
        repeat (3) tick();
        check_writes("nominal");
        chk("nom_checksum", 64'(checksum), 64'hB6);
        chk("nom_words", 64'(words_loaded), 64'd2);
        chk("nom_core_hold", 64'(core_hold), 64'd0);
        chk("nom_byte_ready", 64'(bus.byte_ready), 64'd0);

        // gapped stream with an ignored start in the middle
        exp_q = '{{32'd0, 32'h0000_0013}, {32'd1, 32'h0010_0093}};
        do_start(8'd2);
        send_bytes(3, 4);
        repeat (3) tick();
        check_writes("gapped");
        chk("gap_checksum", 64'(checksum), 64'hB6);
        chk("gap_words", 64'(words_loaded), 64'd2);

        // bad lengths
        do_start(8'd0);
        chk("len0_err", 64'(err), 64'd1);
        chk("len0_hold", 64'(core_hold), 64'd1);
        chk("len0_ready", 64'(bus.byte_ready), 64'd0);
        repeat (3) tick();
        do_start(8'd129);
        chk("len129_err", 64'(err), 64'd1);
        chk("len129_ready", 64'(bus.byte_ready), 64'd0);
        repeat (3) tick();
        check_writes("badlen");

        // timeout after a partial second word
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_q = '{{32'd0, 32'h0403_0201}};
        do_start(8'd4);
        send_bytes(0, -1);
        repeat (TIMEOUT - 1) tick();
        chk("to_err_early", 64'(err), 64'd0);
        tick();
        chk("to_err", 64'(err), 64'd1);
        chk("to_ready", 64'(bus.byte_ready), 64'd0);
        chk("to_hold", 64'(core_hold), 64'd1);
        repeat (4) tick();
        check_writes("timeout");

        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{{32'd0, 32'h4433_2211}};
        do_start(8'd1);
        send_bytes(0, -1);
        repeat (3) tick();
        check_writes("reload");
        chk("reload_err", 64'(err), 64'd0);
        chk("reload_checksum", 64'(checksum), 64'hAA);
        chk("reload_hold", 64'(core_hold), 64'd0);

        // reset mid-load after 6 of 8 bytes, with a byte still offered
        tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        exp_q = '{{32'd0, 32'h0000_0013}};
        do_start(8'd2);
        send_bytes(0, -1);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h10;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.byte_valid = 1'b0;
        chk("mid_rst_hold", 64'(core_hold), 64'd1);
        chk("mid_rst_checksum", 64'(checksum), 64'd0);
        chk("mid_rst_words", 64'(words_loaded), 64'd0);
        chk("mid_rst_we0", 64'(bus.we0), 64'd0);
        chk("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
        repeat (2) tick();
        check_writes("midrst");

        tx_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q = '{{32'd0, 32'hDEAD_BEEF}};
        do_start(8'd1);
        send_bytes(0, -1);
        repeat (3) tick();
        check_writes("after_rst");
        chk("after_rst_words", 64'(words_loaded), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
